gmii_rx_frame_parser: RTL

//  GMII receive front end that sits directly upstream of the CRC-32 checker.
//  It registers the raw GMII RX bus, strips the preamble and SFD, and drives
//  the checker's init, enable and data inputs. It samples the checker's
//  crc_ok at end of frame. It forwards the payload with the 4-byte FCS

---
 rtl/gmii_rx_frame_parser.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gmii_rx_frame_parser.sv
// gmii_rx_frame_parser: GMII RX front end; strips preamble/SFD, feeds CRC-32 checker, forwards payload without FCS
// Ports:
//   clk, reset               GMII RX clock, asynchronous active-high reset
//   gmii_rx_dv/er/rxd        raw GMII receive bus (registered internally)
//   crc_data/init/en         drive an external CRC-32 checker
//   crc_ok                   checker residue match, valid in the end-of-frame cycle
//   rx_data/valid/sof/eof    payload stream with the 4 FCS bytes removed
//   rx_good/bad, rx_len      one-cycle frame verdict and frame length (FCS included)
module gmii_rx_frame_parser #(
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518,
  parameter int MAX_PREAMBLE = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  crc_data,
  output logic        crc_init,
  output logic        crc_en,
  input  logic        crc_ok,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_good,
  output logic        rx_bad,
  output logic [15:0] rx_len
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  localparam int PW = $clog2(MAX_PREAMBLE + 1) + 1;
  localparam logic [PW-1:0] PMAX = PW'(MAX_PREAMBLE);
  localparam logic [15:0] LMIN = 16'(MIN_LEN);
  localparam logic [15:0] LMAX = 16'(MAX_LEN);
  state_t state, state_nxt;
  logic dv1, er1;
  logic [7:0] d1;
  logic [PW-1:0] pcnt;
  logic [15:0] len;
  logic err, first, good;
  logic [2:0] fill;
  logic [4:0][7:0] dl;
  assign crc_data = d1;
  assign crc_en   = (state == DATA) & dv1;
  assign crc_init = state != DATA;
  assign good     = crc_ok & !err & (len >= LMIN) & (len <= LMAX);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dv1 <= 1'b0;
      er1 <= 1'b0;
      d1  <= '0;
    end else begin
      dv1 <= gmii_rx_dv;
      er1 <= gmii_rx_er;
      d1  <= gmii_rxd;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dv1) state_nxt = d1 == 8'h55 ? PRE : d1 == 8'hD5 ? DATA : DROP;
      PRE: begin
        if (!dv1)              state_nxt = IDLE;
        else if (er1)          state_nxt = DROP;
        else if (d1 == 8'h55)  state_nxt = pcnt >= PMAX ? DROP : PRE;
        else if (d1 == 8'hD5)  state_nxt = DATA;
        else                   state_nxt = DROP;
      end
      default: if (!dv1) state_nxt = IDLE;
    endcase
  end
  // count starts at 1 because the byte that moves IDLE->PRE is the first 0x55
  always_ff @(posedge clk or posedge reset)
    if (reset)                                  pcnt <= PW'(1);
    else if (state == IDLE)                     pcnt <= PW'(1);
    else if (state == PRE && dv1 && d1 == 8'h55) pcnt <= pcnt + PW'(1);
  // dl[0] is the newest byte, dl[4] the oldest; the last 4 held at end of frame are the FCS
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_good  <= 1'b0;
      rx_bad   <= 1'b0;
      rx_len   <= '0;
      len      <= '0;
      err      <= 1'b0;
      fill     <= '0;
      first    <= 1'b1;
      dl       <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_good  <= 1'b0;
      rx_bad   <= 1'b0;
      if (state != DATA) begin
        len   <= '0;
        err   <= 1'b0;
        fill  <= '0;
        first <= 1'b1;
      end else if (dv1) begin
        len  <= &len ? len : len + 16'd1;
        err  <= err | er1;
        dl   <= {dl[3:0], d1};
        fill <= fill == 3'd5 ? fill : fill + 3'd1;
        if (fill == 3'd5) begin
          rx_valid <= 1'b1;
          rx_data  <= dl[4];
          rx_sof   <= first;
          first    <= 1'b0;
        end
      end else begin
        rx_len  <= len;
        rx_good <= good;
        rx_bad  <= !good;
        if (fill == 3'd5) begin
          rx_valid <= 1'b1;
          rx_eof   <= 1'b1;
          rx_data  <= dl[4];
          rx_sof   <= first;
        end
      end
    end
endmodule
